// File: rtl/dma_cfg_pkg.sv
// Shared definitions for the DMA channel configuration sequencer.
//   - state_e      : sequencer FSM states
//   - REG_*        : register-file word addresses
//   - *_BIT        : bit positions inside CTRL and STATUS
package dma_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE_RD   = 3'd0,
        ST_IDLE_CHK  = 3'd1,
        ST_FETCH     = 3'd2,
        ST_ISSUE     = 3'd3,
        ST_WAIT      = 3'd4,
        ST_WR_STATUS = 3'd5,
        ST_WR_CTRL   = 3'd6
    } state_e;

    localparam int unsigned REG_CTRL   = 0;
    localparam int unsigned REG_SRC    = 1;
    localparam int unsigned REG_DST    = 2;
    localparam int unsigned REG_LEN    = 3;
    localparam int unsigned REG_STATUS = 4;

    localparam int unsigned CTRL_START_BIT  = 0;
    localparam int unsigned STATUS_DONE_BIT = 0;
    localparam int unsigned STATUS_ERR_BIT  = 1;

endpackage

// File: rtl/dma_cfg_sequencer.sv
// DMA channel sequencer between the configuration register file and the
// transfer engine. Polls CTRL.start through read port 2, fetches SRC/DST/LEN,
// hands the descriptor to the engine with valid/ready, waits for done, then
// writes STATUS and clears CTRL through the shared write port, where the AXI
// slave always has priority.
//
// Ports:
//   clk, resetn                        clock, async active-low reset
//   slv_write_enable/_writeAddr/_datain AXI-slave write request
//   rf_write_enable/_writeAddr/_datain  register-file write port (comb mux)
//   rf_read_enable2/rf_readAddr2        read port 2 request (registered)
//   rf_dataout2                         read port 2 data, one cycle after request
//   xfer_valid/_ready, xfer_src/_dst/_len  descriptor handshake
//   xfer_done, xfer_err                 completion pulse and error qualifier
//   busy                                high outside the CTRL polling loop
module dma_cfg_sequencer
    import dma_cfg_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  slv_write_enable,
    input  logic [ADDR_WIDTH-1:0] slv_writeAddr,
    input  logic [DATA_WIDTH-1:0] slv_datain,
    output logic                  rf_write_enable,
    output logic [ADDR_WIDTH-1:0] rf_writeAddr,
    output logic [DATA_WIDTH-1:0] rf_datain,
    output logic                  rf_read_enable2,
    output logic [ADDR_WIDTH-1:0] rf_readAddr2,
    input  logic [DATA_WIDTH-1:0] rf_dataout2,
    output logic                  xfer_valid,
    input  logic                  xfer_ready,
    output logic [DATA_WIDTH-1:0] xfer_src,
    output logic [DATA_WIDTH-1:0] xfer_dst,
    output logic [DATA_WIDTH-1:0] xfer_len,
    input  logic                  xfer_done,
    input  logic                  xfer_err,
    output logic                  busy
);

    state_e                state_q, state_d;
    logic [1:0]            idx_q, idx_d;
    logic [DATA_WIDTH-1:0] src_q, dst_q, len_q;
    logic [1:0]            status_q;
    logic                  rd_en_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic                  poll_vld_q;

    logic                  rd_req_d;
    logic [ADDR_WIDTH-1:0] rd_addr_d;
    logic                  fsm_wr_req;
    logic [ADDR_WIDTH-1:0] fsm_wr_addr;
    logic [DATA_WIDTH-1:0] fsm_wr_data;
    logic                  len_zero;

    // LEN arrives on the read port during the last FETCH cycle, so the
    // zero-length decision looks at the incoming word rather than len_q.
    assign len_zero = (rf_dataout2 == '0);

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE_RD;
            idx_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        idx_d   = 2'd0;
        case (state_q)
            ST_IDLE_RD:  state_d = ST_IDLE_CHK;
            // poll_vld_q guards the first check after reset, when no CTRL
            // read has been issued yet and rf_dataout2 is stale.
            ST_IDLE_CHK: state_d = (poll_vld_q && rf_dataout2[CTRL_START_BIT])
                                   ? ST_FETCH : ST_IDLE_RD;
            ST_FETCH: begin
                if (idx_q == 2'd3) begin
                    state_d = len_zero ? ST_WR_STATUS : ST_ISSUE;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            ST_ISSUE:     if (xfer_ready)        state_d = ST_WAIT;
            ST_WAIT:      if (xfer_done)         state_d = ST_WR_STATUS;
            ST_WR_STATUS: if (!slv_write_enable) state_d = ST_WR_CTRL;
            ST_WR_CTRL:   if (!slv_write_enable) state_d = ST_IDLE_RD;
            default:      state_d = ST_IDLE_RD;
        endcase
    end

    // Output logic
    always_comb begin
        xfer_valid  = (state_q == ST_ISSUE);
        busy        = (state_q != ST_IDLE_RD) && (state_q != ST_IDLE_CHK);
        fsm_wr_req  = (state_q == ST_WR_STATUS) || (state_q == ST_WR_CTRL);
        fsm_wr_addr = ADDR_WIDTH'(REG_CTRL);
        fsm_wr_data = '0;
        if (state_q == ST_WR_STATUS) begin
            fsm_wr_addr = ADDR_WIDTH'(REG_STATUS);
            fsm_wr_data = DATA_WIDTH'(status_q);
        end
        // The read request is registered from the next state so that it is
        // on the port during the requesting state itself and the data is
        // back exactly one cycle later (IDLE_CHK, FETCH idx+1).
        rd_req_d  = 1'b0;
        rd_addr_d = ADDR_WIDTH'(REG_CTRL);
        if (state_d == ST_IDLE_RD) begin
            rd_req_d = 1'b1;
        end else if (state_d == ST_FETCH && idx_d != 2'd3) begin
            rd_req_d  = 1'b1;
            rd_addr_d = ADDR_WIDTH'(REG_SRC) + ADDR_WIDTH'(idx_d);
        end
    end

    // Read request register, descriptor capture and status latch
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            poll_vld_q <= 1'b0;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            status_q   <= 2'b00;
        end else begin
            rd_en_q    <= rd_req_d;
            rd_addr_q  <= rd_addr_d;
            poll_vld_q <= rd_en_q;
            if (state_q == ST_FETCH) begin
                case (idx_q)
                    2'd1:    src_q <= rf_dataout2;
                    2'd2:    dst_q <= rf_dataout2;
                    2'd3:    len_q <= rf_dataout2;
                    default: ;
                endcase
                if (idx_q == 2'd3 && len_zero) begin
                    status_q[STATUS_ERR_BIT]  <= 1'b1;
                    status_q[STATUS_DONE_BIT] <= 1'b0;
                end
            end
            if (state_q == ST_WAIT && xfer_done) begin
                status_q[STATUS_ERR_BIT]  <= xfer_err;
                status_q[STATUS_DONE_BIT] <= 1'b1;
            end
        end
    end

    assign rf_read_enable2 = rd_en_q;
    assign rf_readAddr2    = rd_addr_q;
    assign xfer_src        = src_q;
    assign xfer_dst        = dst_q;
    assign xfer_len        = len_q;

    // Write-port arbiter: the slave always wins and the FSM simply holds
    // its state until the port is free.
    assign rf_write_enable = slv_write_enable | fsm_wr_req;
    assign rf_writeAddr    = slv_write_enable ? slv_writeAddr : fsm_wr_addr;
    assign rf_datain       = slv_write_enable ? slv_datain    : fsm_wr_data;

endmodule

// File: tb/tb_dma_cfg_sequencer.sv
module tb_dma_cfg_sequencer;

    localparam int DW = 32;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          resetn;
    logic          slv_write_enable;
    logic [AW-1:0] slv_writeAddr;
    logic [DW-1:0] slv_datain;
    logic          rf_write_enable;
    logic [AW-1:0] rf_writeAddr;
    logic [DW-1:0] rf_datain;
    logic          rf_read_enable2;
    logic [AW-1:0] rf_readAddr2;
    logic [DW-1:0] rf_dataout2;
    logic          xfer_valid;
    logic          xfer_ready;
    logic [DW-1:0] xfer_src, xfer_dst, xfer_len;
    logic          xfer_done;
    logic          xfer_err;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;
    int hs_cnt   = 0;
    int vld_cnt  = 0;

    logic [DW-1:0] regs [0:255];

    always #5 clk = ~clk;

    dma_cfg_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .slv_write_enable (slv_write_enable),
        .slv_writeAddr    (slv_writeAddr),
        .slv_datain       (slv_datain),
        .rf_write_enable  (rf_write_enable),
        .rf_writeAddr     (rf_writeAddr),
        .rf_datain        (rf_datain),
        .rf_read_enable2  (rf_read_enable2),
        .rf_readAddr2     (rf_readAddr2),
        .rf_dataout2      (rf_dataout2),
        .xfer_valid       (xfer_valid),
        .xfer_ready       (xfer_ready),
        .xfer_src         (xfer_src),
        .xfer_dst         (xfer_dst),
        .xfer_len         (xfer_len),
        .xfer_done        (xfer_done),
        .xfer_err         (xfer_err),
        .busy             (busy)
    );

    // Register-file model: synchronous read with one cycle latency.
    always @(posedge clk) begin
        if (rf_read_enable2) rf_dataout2 <= regs[rf_readAddr2];
        if (rf_write_enable) regs[rf_writeAddr] <= rf_datain;
        if (xfer_valid && xfer_ready) hs_cnt <= hs_cnt + 1;
        if (xfer_valid) vld_cnt <= vld_cnt + 1;
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic slv_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        slv_write_enable = 1'b1;
        slv_writeAddr    = a;
        slv_datain       = d;
        @(negedge clk);
        slv_write_enable = 1'b0;
    endtask

    task automatic wait_valid();
        int cnt = 0;
        while (!xfer_valid && cnt < 60) begin
            @(negedge clk);
            cnt++;
        end
        check("valid_timeout", {31'd0, xfer_valid}, 1);
    endtask

    task automatic handshake();
        xfer_ready = 1'b1;
        @(negedge clk);
        xfer_ready = 1'b0;
        check("valid_drop_after_hs", {31'd0, xfer_valid}, 0);
    endtask

    task automatic pulse_done(input logic err);
        xfer_done = 1'b1;
        xfer_err  = err;
        @(negedge clk);
        xfer_done = 1'b0;
        xfer_err  = 1'b0;
    endtask

    // Called at the negedge of the WR_STATUS cycle with the slave idle.
    task automatic expect_writeback(input logic [DW-1:0] exp_status);
        #1;
        check("wb_status_we",   {31'd0, rf_write_enable}, 1);
        check("wb_status_addr", {24'd0, rf_writeAddr}, 4);
        check("wb_status_data", rf_datain, exp_status);
        @(negedge clk);
        check("wb_ctrl_addr", {24'd0, rf_writeAddr}, 0);
        check("wb_ctrl_data", rf_datain, 0);
        @(negedge clk);
        check("wb_idle_busy", {31'd0, busy}, 0);
        check("wb_status_reg", regs[4], exp_status);
        check("wb_ctrl_reg", regs[0], 0);
    endtask

    initial begin
        int first_k;
        int hs0;
        int v0;
        int cnt;
        logic stable;

        resetn = 1'b0;
        slv_write_enable = 1'b0;
        slv_writeAddr = '0;
        slv_datain = '0;
        xfer_ready = 1'b0;
        xfer_done = 1'b0;
        xfer_err = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_valid", {31'd0, xfer_valid}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_rd_en", {31'd0, rf_read_enable2}, 0);
        check("rst_src", xfer_src, 0);
        check("rst_we", {31'd0, rf_write_enable}, 0);
        slv_write_enable = 1'b1;
        slv_writeAddr = 8'd1;
        slv_datain = 32'h100;
        #1;
        check("rst_slv_pass_we", {31'd0, rf_write_enable}, 1);
        check("rst_slv_pass_data", rf_datain, 32'h100);
        @(negedge clk);
        slv_write_enable = 1'b0;
        slv_wr(8'd2, 32'h200);
        slv_wr(8'd3, 32'd16);
        slv_wr(8'd0, 32'd0);
        resetn = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_busy", {31'd0, busy}, 0);

        // Test 1: latency and basic transfer, ready tied high
        slv_wr(8'd0, 32'd1);
        cnt = 0;
        while (!(rf_read_enable2 && rf_readAddr2 == 8'd0 && !busy) && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        check("poll_sync", {31'd0, rf_read_enable2}, 1);
        xfer_ready = 1'b1;
        first_k = 0;
        for (int k = 2; k <= 8; k++) begin
            @(negedge clk);
            if (k == 3) check("fetch_src_addr", {24'd0, rf_readAddr2}, 1);
            if (xfer_valid && first_k == 0) begin
                first_k = k;
                check("t1_src", xfer_src, 32'h100);
                check("t1_dst", xfer_dst, 32'h200);
                check("t1_len", xfer_len, 32'd16);
            end
        end
        xfer_ready = 1'b0;
        check("t1_valid_cycle", first_k, 7);
        check("t1_wait_valid", {31'd0, xfer_valid}, 0);
        check("t1_wait_busy", {31'd0, busy}, 1);
        pulse_done(1'b0);
        expect_writeback(32'd1);

        // Test 2/3: ready held low, spurious done in ISSUE, error status
        slv_wr(8'd1, 32'h111);
        slv_wr(8'd2, 32'h222);
        slv_wr(8'd3, 32'h33);
        slv_wr(8'd0, 32'd1);
        wait_valid();
        hs0 = hs_cnt;
        stable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            xfer_done = (k == 2);
            xfer_err  = (k == 2);
            @(negedge clk);
            if (!(xfer_valid && xfer_src == 32'h111 && xfer_dst == 32'h222 && xfer_len == 32'h33))
                stable = 1'b0;
        end
        xfer_done = 1'b0;
        xfer_err = 1'b0;
        check("t2_stable", {31'd0, stable}, 1);
        handshake();
        check("t2_one_hs", hs_cnt - hs0, 1);
        repeat (2) @(negedge clk);
        pulse_done(1'b1);
        expect_writeback(32'd3);

        // Test 4: zero length
        v0 = vld_cnt;
        slv_wr(8'd3, 32'd0);
        slv_wr(8'd0, 32'd1);
        cnt = 0;
        while (!(rf_write_enable && rf_writeAddr == 8'd4) && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        expect_writeback(32'd2);
        check("t4_no_valid", vld_cnt - v0, 0);

        // Test 5: slave SRC write mid-WAIT, then slave stalls the STATUS write
        slv_wr(8'd1, 32'h500);
        slv_wr(8'd2, 32'h600);
        slv_wr(8'd3, 32'd8);
        slv_wr(8'd0, 32'd1);
        wait_valid();
        check("t5_src", xfer_src, 32'h500);
        handshake();
        slv_wr(8'd1, 32'h999);
        check("t5_src_held", xfer_src, 32'h500);
        pulse_done(1'b0);
        for (int k = 0; k < 3; k++) begin
            slv_write_enable = 1'b1;
            slv_writeAddr = 8'(5 + k);
            slv_datain = 32'hA0 + k;
            #1;
            check("t5_slv_addr", {24'd0, rf_writeAddr}, 5 + k);
            check("t5_slv_data", rf_datain, 32'hA0 + k);
            @(negedge clk);
        end
        slv_write_enable = 1'b0;
        expect_writeback(32'd1);
        check("t5_slv_reg5", regs[5], 32'hA0);
        check("t5_slv_reg7", regs[7], 32'hA2);

        // Test 6: new SRC used, reset mid-WAIT, restart
        slv_wr(8'd0, 32'd1);
        wait_valid();
        check("t6_src_new", xfer_src, 32'h999);
        handshake();
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check("t6_rst_valid", {31'd0, xfer_valid}, 0);
        check("t6_rst_busy", {31'd0, busy}, 0);
        check("t6_rst_src", xfer_src, 0);
        check("t6_rst_rd", {31'd0, rf_read_enable2}, 0);
        @(negedge clk);
        resetn = 1'b1;
        wait_valid();
        check("t6_restart_src", xfer_src, 32'h999);
        check("t6_restart_len", xfer_len, 32'd8);
        handshake();
        pulse_done(1'b0);
        expect_writeback(32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dma_cfg_sequencer.md
# dma_cfg_sequencer

Channel sequencer that sits between the DMA configuration register file and the transfer engine. It polls the CTRL register through register-file read port 2 and fetches SRC/DST/LEN when start is set. It hands the descriptor to the engine with a valid/ready handshake, then writes STATUS and clears CTRL. It owns the register file's single write port and shares it with the AXI slave; the slave always wins.

## Interface
- DATA_WIDTH, 32, register/data width
- ADDR_WIDTH, 8, register-file address width
- clk  in  1  single clock, all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- slv_write_enable / slv_writeAddr / slv_datain  in  1 / ADDR_WIDTH / DATA_WIDTH  AXI-slave write request
- rf_write_enable / rf_writeAddr / rf_datain  out  1 / ADDR_WIDTH / DATA_WIDTH  to register-file write port (combinational mux)
- rf_read_enable2 / rf_readAddr2  out  1 / ADDR_WIDTH  register-file read port 2 request (registered)
- rf_dataout2  in  DATA_WIDTH  read port 2 data, valid one cycle after the request
- xfer_valid  out  1  descriptor valid
- xfer_ready  in  1  engine accepts descriptor
- xfer_src / xfer_dst / xfer_len  out  DATA_WIDTH each  descriptor fields
- xfer_done  in  1  one-cycle pulse: engine finished
- xfer_err  in  1  error qualifier, sampled with xfer_done
- busy  out  1  high in every state except IDLE_RD/IDLE_CHK

## Operation
- Register map, word addresses: CTRL=0 (bit0 start), SRC=1, DST=2, LEN=3, STATUS=4 (bit0 done, bit1 err).
- States: IDLE_RD -> IDLE_CHK -> FETCH -> ISSUE -> WAIT -> WR_STATUS -> WR_CTRL -> IDLE_RD.
- IDLE_RD: assert rf_read_enable2 with addr CTRL, then go to IDLE_CHK.
- IDLE_CHK: rf_dataout2[0]=1 -> FETCH. Otherwise -> IDLE_RD, so CTRL is polled every 2 cycles.
- FETCH: 2-bit counter idx 0..3.
  - idx 0..2 issue reads of SRC, DST, LEN.
  - idx 1..3 capture the previous read into src_q, dst_q, len_q.
  - After idx 3: if len_q==0 go straight to WR_STATUS with STATUS=2'b10; otherwise go to ISSUE.
- ISSUE: xfer_valid=1 with src/dst/len held stable until xfer_ready. On the handshake cycle, go to WAIT. Fields must not change while valid.
- WAIT: on xfer_done, latch STATUS={err=xfer_err, done=1} and go to WR_STATUS. xfer_done in any other state is ignored.
- WR_STATUS / WR_CTRL: request the write port (STATUS value / CTRL=0).
  - If slv_write_enable=1 that cycle, the slave write passes through and the FSM stays put (stall).
  - Otherwise the FSM write goes out and the FSM advances.
- Write mux: slv_write_enable ? slave fields : FSM fields. rf_write_enable = slv_write_enable | fsm_wr_req.
- A slave write to CTRL/SRC/DST/LEN during FETCH..WAIT does not affect the captured descriptor.

## Timing
- Reset values: all outputs 0 (rf_write_enable follows slv_write_enable combinationally), state=IDLE_RD, src_q/dst_q/len_q/status_q=0, idx=0.
- Read latency is 1 cycle: a request registered at edge n is consumed at edge n+2 (IDLE_CHK/FETCH capture).
- Minimum cycles from a start bit already in CTRL to xfer_valid: IDLE_RD, IDLE_CHK, 4 FETCH cycles, ISSUE asserts, so 7 edges.
- Slave write latency is 0 added cycles. FSM writes stall indefinitely under continuous slave writes; there is no fairness requirement.
- After WR_CTRL commits, the next CTRL poll sees 0 unless the slave rewrote start.
- Asynchronous reset mid-operation: immediate return to reset values. xfer_valid drops and a pending status write is lost.

## Structure
- Package dma_cfg_pkg: state enum, register address constants (CTRL/SRC/DST/LEN/STATUS), CTRL/STATUS bit indices.
- Single module, no sub-modules. The write-port arbiter stays as inline combinational logic.

## Test plan
- CTRL=1, SRC=0x100, DST=0x200, LEN=16, xfer_ready tied 1: xfer_valid on the 7th edge with 0x100/0x200/16. After xfer_done: STATUS=1, CTRL=0.
- xfer_ready held low 5 cycles: valid and fields stable throughout, exactly one handshake.
- xfer_done with xfer_err=1: STATUS=3.
- LEN=0: no xfer_valid ever, STATUS=2, CTRL cleared.
- slv_write_enable held 3 cycles during WR_STATUS: the slave writes land first, the STATUS write follows on the 4th cycle. Slave writes SRC=0x999 mid-WAIT: the next transfer uses 0x999, the current one does not.
- resetn low during WAIT: outputs 0 the same cycle. After release, the FSM polls CTRL and restarts if start is still 1.
